// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM sequencing the shared-memory multicycle MIPS datapath.
// Define MC_INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module mips_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_load,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       data_to_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    S_IF, S_ID, S_REX, S_RWB, S_MADDR, S_MRD, S_LWB, S_MWR,
    S_BEQ, S_IEX, S_IWB, S_SEX, S_SWB, S_JMP, S_JAL, S_JR
  } state_e;
  state_e state_q, state_d;
  always_ff @(posedge clk) state_q <= rst ? S_IF : state_d;
  always_comb begin
    state_d = S_IF;
    {mem_read, mem_write, i_or_d, ir_write, alu_src_a, alu_src_b, alu_op, pc_src,
     pc_load, reg_write, reg_dst, data_to_write, mem_to_reg, illegal} = '0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_load   = mem_ready;
        state_d   = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000: state_d = S_REX;
          6'b100011, 6'b101011: state_d = S_MADDR;
          6'b000100: state_d = S_BEQ;
          6'b001001: state_d = S_IEX;
          6'b001010: state_d = S_SEX;
          6'b000010: state_d = S_JMP;
          6'b000011: state_d = S_JAL;
          6'b000110: state_d = S_JR;
          default:   illegal = 1'b1;
        endcase
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == 6'b101011) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_LWB : S_MRD;
      end
      S_LWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = mem_ready ? S_IF : S_MWR;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_load   = zero;
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IWB;
      end
      S_IWB: reg_write = 1'b1;
      S_SEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_SWB;
      end
      S_SWB: begin
        reg_write     = 1'b1;
        data_to_write = 2'b10;
      end
      S_JMP: begin
        pc_load = 1'b1;
        pc_src  = 2'b10;
      end
      S_JAL: begin
        pc_load       = 1'b1;
        pc_src        = 2'b10;
        reg_write     = 1'b1;
        reg_dst       = 2'b10;
        data_to_write = 2'b01;
      end
      S_JR: begin
        pc_load = 1'b1;
        pc_src  = 2'b11;
      end
      default: state_d = S_IF;
    endcase
    // reset kills any in-flight request or write in the same cycle
    if (rst)
      {mem_read, mem_write, i_or_d, ir_write, alu_src_a, alu_src_b, alu_op, pc_src,
       pc_load, reg_write, reg_dst, data_to_write, mem_to_reg, illegal} = '0;
  end
`ifdef MC_INSTR_COUNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;
  // any return to IF except from IF itself or the illegal-opcode exit in ID
  assign retire = (state_d == S_IF) && (state_q != S_IF) && (state_q != S_ID);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_q + CNT_W'(retire);
  assign instr_count = rst ? '0 : cnt_q;
`else
  assign instr_count = '0;
`endif
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: instruction-level microstep model vs. the controller, directed then random.
module tb_mips_multicycle_controller;
  localparam int CNT_W = 32;
  localparam int P_FETCH = 0, P_DEC = 1, P_REX = 2, P_RWB = 3, P_ADDR = 4, P_RD = 5, P_LWB = 6,
                 P_WR = 7, P_BEQ = 8, P_IEX = 9, P_IWB = 10, P_SEX = 11, P_SWB = 12,
                 P_J = 13, P_JAL = 14, P_JR = 15;
  logic clk = 1'b0, rst, zero, mem_ready;
  logic [5:0] opcode;
  logic mem_read, mem_write, i_or_d, ir_write, alu_src_a, pc_load, reg_write, mem_to_reg, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src, reg_dst, data_to_write;
  logic [CNT_W-1:0] instr_count;
  int checks = 0, failures = 0;
  int cur = P_FETCH, lat = 0, last_lat = 0, ill_seen = 0;
  int plan[$];
  logic [CNT_W-1:0] cnt_m = '0;
  logic [5:0] legal_ops [9] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h09, 6'h0a, 6'h02, 6'h03, 6'h06};

  always #5 clk = ~clk;

  mips_multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .pc_load(pc_load), .reg_write(reg_write), .reg_dst(reg_dst), .data_to_write(data_to_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .instr_count(instr_count));

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // expected control word for one microstep, bit order matches act_vec()
  function automatic logic [18:0] outs(input int s, input logic mr, input logic z, input logic [5:0] op);
    logic mrd = 0, mwr = 0, iod = 0, irw = 0, asa = 0, pl = 0, rw = 0, m2r = 0, ill = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0, rd = 0, dtw = 0;
    case (s)
      P_FETCH: begin mrd = 1; asb = 2'b01; irw = mr; pl = mr; end
      P_DEC:   begin asb = 2'b11; ill = !is_legal(op); end
      P_REX:   begin asa = 1; aop = 2'b10; end
      P_RWB:   begin rw = 1; rd = 2'b01; end
      P_ADDR:  begin asa = 1; asb = 2'b10; end
      P_RD:    begin mrd = 1; iod = 1; end
      P_LWB:   begin rw = 1; m2r = 1; end
      P_WR:    begin mwr = 1; iod = 1; end
      P_BEQ:   begin asa = 1; aop = 2'b01; psrc = 2'b01; pl = z; end
      P_IEX:   begin asa = 1; asb = 2'b10; end
      P_IWB:   rw = 1;
      P_SEX:   begin asa = 1; asb = 2'b10; aop = 2'b11; end
      P_SWB:   begin rw = 1; dtw = 2'b10; end
      P_J:     begin pl = 1; psrc = 2'b10; end
      P_JAL:   begin pl = 1; psrc = 2'b10; rw = 1; rd = 2'b10; dtw = 2'b01; end
      P_JR:    begin pl = 1; psrc = 2'b11; end
      default: ;
    endcase
    return {mrd, mwr, iod, irw, asa, asb, aop, psrc, pl, rw, rd, dtw, m2r, ill};
  endfunction

  function automatic logic [18:0] act_vec();
    return {mem_read, mem_write, i_or_d, ir_write, alu_src_a, alu_src_b, alu_op, pc_src,
            pc_load, reg_write, reg_dst, data_to_write, mem_to_reg, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h (step %0d)", name, $time, act, exp, cur);
    end
  endtask

  task automatic drive(input logic r, input logic mr, input logic z, input logic [5:0] op);
    rst = r; mem_ready = mr; zero = z; opcode = op;
    #1;
    chk("outputs", 32'(act_vec()), r ? 32'd0 : 32'(outs(cur, mr, z, op)));
`ifdef MC_INSTR_COUNT_EN
    chk("instr_count", instr_count, r ? 32'd0 : cnt_m);
`else
    chk("instr_count", instr_count, 32'd0);
`endif
    if (!r && illegal) ill_seen++;
  endtask

  // advance the microstep model across one clock edge
  task automatic step();
    @(posedge clk);
    if (rst) begin
      cur = P_FETCH; plan = {}; cnt_m = '0; lat = 0;
    end else begin
      lat++;
      if (!((cur == P_FETCH || cur == P_RD || cur == P_WR) && !mem_ready)) begin
        if (cur == P_FETCH) begin
          case (opcode)
            6'h00: plan = {P_DEC, P_REX, P_RWB};
            6'h23: plan = {P_DEC, P_ADDR, P_RD, P_LWB};
            6'h2b: plan = {P_DEC, P_ADDR, P_WR};
            6'h04: plan = {P_DEC, P_BEQ};
            6'h09: plan = {P_DEC, P_IEX, P_IWB};
            6'h0a: plan = {P_DEC, P_SEX, P_SWB};
            6'h02: plan = {P_DEC, P_J};
            6'h03: plan = {P_DEC, P_JAL};
            6'h06: plan = {P_DEC, P_JR};
            default: plan = {P_DEC};
          endcase
          cur = plan.pop_front();
        end else if (plan.size() == 0) begin
          if (cur != P_DEC) cnt_m++;
          cur = P_FETCH; last_lat = lat; lat = 0;
        end else cur = plan.pop_front();
      end
    end
    @(negedge clk);
  endtask

  task automatic go(input logic r, input logic mr, input logic z, input logic [5:0] op);
    drive(r, mr, z, op);
    step();
  endtask

  initial begin
    logic [5:0] op;
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    @(negedge clk);
    go(1, 1, 0, 6'h00);
    go(1, 1, 0, 6'h00);
    // R-type, no wait states
    drive(0, 1, 0, 6'h00);
    chk("if_fetch_strobes", 32'({mem_read, ir_write, pc_load}), 32'b111);
    step();
    repeat (3) go(0, 1, 0, 6'h00);
    chk("lat_rtype", last_lat, 4);
    // lw with three stalled MRD cycles
    repeat (3) go(0, 1, 0, 6'h23);
    repeat (3) begin
      drive(0, 0, 0, 6'h23);
      chk("mrd_hold", 32'({mem_read, i_or_d}), 32'b11);
      step();
    end
    go(0, 1, 0, 6'h23);
    drive(0, 1, 0, 6'h23);
    chk("lwb_mem_to_reg", 32'({reg_write, mem_to_reg}), 32'b11);
    step();
    chk("lat_lw_stall", last_lat, 8);
    // beq taken then not taken
    repeat (2) go(0, 1, 1, 6'h04);
    drive(0, 1, 1, 6'h04);
    chk("beq_taken", 32'({pc_load, pc_src}), 32'b101);
    step();
    chk("lat_beq_t", last_lat, 3);
    repeat (2) go(0, 1, 0, 6'h04);
    drive(0, 1, 0, 6'h04);
    chk("beq_not_taken", 32'({pc_load, pc_src}), 32'b001);
    step();
    chk("lat_beq_nt", last_lat, 3);
    // jal
    repeat (2) go(0, 1, 0, 6'h03);
    drive(0, 1, 0, 6'h03);
    chk("jal_word", 32'({pc_load, pc_src, reg_write, reg_dst, data_to_write}), 32'b1_10_1_10_01);
    step();
    chk("lat_jal", last_lat, 3);
    // unsupported opcode
    ill_seen = 0;
    repeat (2) go(0, 1, 0, 6'h3f);
    chk("illegal_pulses", ill_seen, 1);
    chk("lat_illegal", last_lat, 2);
`ifdef MC_INSTR_COUNT_EN
    chk("count_after_directed", instr_count, 5);
`else
    chk("count_after_directed", instr_count, 0);
`endif
    // reset during a stalled sw
    repeat (3) go(0, 1, 0, 6'h2b);
    repeat (2) go(0, 0, 0, 6'h2b);
    drive(1, 0, 0, 6'h2b);
    chk("rst_drops_write", 32'(mem_write), 0);
    step();
    drive(0, 0, 0, 6'h2b);
    chk("fetch_after_rst", 32'(mem_read), 1);
    chk("count_after_rst", instr_count, 0);
    step();
    // randomized run
    for (int n = 0; n < 4000; n++) begin
      op = opcode;
      if (cur == P_FETCH) begin
        int k = int'($urandom_range(0, 9));
        op = (k < 9) ? legal_ops[k] : 6'($urandom);
      end
      go(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 1'($urandom), op);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Moore FSM that sequences the shared-memory multicycle MIPS datapath (single memory, IR, A/B, ALUOut, MDR registers).
- Drives the existing alu_controller through alu_op.
- Supports the same ISA subset as the single-cycle core: R-type, lw, sw, beq, addi, j, jal, jr, slti.
- Memory accesses use a ready handshake, so fetch and data phases may stall.

Parameters:
- CNT_W, 32, width of the optional retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  IR[31:26], valid from the ID state onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A reg.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_op  out  2  to alu_controller: 00 add, 01 sub, 10 func-decoded, 11 slt.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 A reg.
- pc_load  out  1  PC write enable (already gated with zero for beq).
- reg_write  out  1  register file write.
- reg_dst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- data_to_write  out  2  write-data select: 00 ALUOut/MDR per mem_to_reg, 01 PC, 10 slt result.
- mem_to_reg  out  1  write-data select: 1 = MDR.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. While rst=1, every output is 0. On the first clk edge with rst=0, state=IF.
- State register: 4 bits. Outputs decode from state only, except where gated by mem_ready or zero. Any output not listed for a state is 0.
- IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=pc_load=mem_ready.
  - Stay in IF while mem_ready=0; go to ID when mem_ready=1.
- ID: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> REX
  - 100011 or 101011 -> MADDR
  - 000100 -> BEQ
  - 001001 -> IEX
  - 001010 -> SEX
  - 000010 -> JMP
  - 000011 -> JAL
  - 000110 -> JR
  - any other opcode -> IF, with illegal=1 for this ID cycle only.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
- RWB: reg_write=1, reg_dst=01 -> IF.
- MADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MRD if lw, MWR if sw.
- MRD: mem_read=1, i_or_d=1. Hold until mem_ready, then -> LWB.
- LWB: reg_write=1, reg_dst=00, mem_to_reg=1 -> IF.
- MWR: mem_write=1, i_or_d=1. Hold until mem_ready, then -> IF.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_load=zero -> IF.
- IEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> IWB.
- IWB: reg_write=1, reg_dst=00 -> IF.
- SEX: alu_src_a=1, alu_src_b=10, alu_op=11 -> SWB.
- SWB: reg_write=1, reg_dst=00, data_to_write=10 -> IF.
- JMP: pc_load=1, pc_src=10 -> IF.
- JAL: pc_load=1, pc_src=10, reg_write=1, reg_dst=10, data_to_write=01 (PC already incremented) -> IF.
- JR: pc_load=1, pc_src=11 -> IF.
- Latency with zero wait states:
  - R, addi, slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
  - Each mem_ready=0 cycle in IF, MRD or MWR adds one cycle.
- Handshake rules:
  - mem_read and mem_write are never both 1.
  - A request stays asserted, with a stable i_or_d, until a cycle where mem_ready=1.
  - mem_ready is ignored in states with no request.
- rst asserted mid-instruction (including a stalled MRD or MWR): all outputs are 0 in that same cycle and the request is dropped. No register or memory write occurs.
- Encoding of unreachable state codes: next state = IF, outputs all 0.

Optional Feature:
- Macro: MC_INSTR_COUNT_EN.
- Defined:
  - instr_count increments by 1 on every transition into IF from a completion state (RWB, LWB, MWR with mem_ready, BEQ, IWB, SWB, JMP, JAL, JR).
  - The illegal path does not increment.
  - Reset to 0; wraps modulo 2^CNT_W.
- Undefined: instr_count is constant 0 and no counter flops are synthesised.

Test Plan:
- Reset, then hold mem_ready=1 with an R-type (opcode 000000) -> state sequence IF, ID, REX, RWB. reg_write=1 and reg_dst=01 only in RWB. pc_load=1 only in IF.
- lw (100011) with mem_ready low for 3 cycles in MRD -> mem_read=1 and i_or_d=1 held for 4 cycles, then LWB with mem_to_reg=1. Total 8 cycles.
- beq (000100) with zero=1, then again with zero=0 -> pc_load=1 with pc_src=01 in BEQ, then pc_load=0. Both return to IF after 3 cycles.
- jal (000011) -> JAL asserts pc_load=1, pc_src=10, reg_write=1, reg_dst=10, data_to_write=01 in one cycle.
- Opcode 111111 -> illegal=1 for exactly one cycle in ID, next state IF, no reg_write. With MC_INSTR_COUNT_EN, instr_count is unchanged.
- rst=1 during a stalled MWR -> mem_write=0 in the same cycle. After rst drops, IF with mem_read=1. With the macro defined, instr_count=0.
